fg_fetch_sram_port: RTL and testbench

// Serves the pipeline's foreground pixel requests (signed x/y + active) from the external foreground SRAM.

---
 rtl/fg_fetch_sram_port.sv | 119 +++++++++++
 tb/tb_fg_fetch_sram_port.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fg_fetch_sram_port.sv
// Foreground SRAM port: fixed-latency pixel fetch for the pipeline, with a small
// write FIFO that drains into the shared single-port SRAM on cycles without a read.
module fg_fetch_sram_port #(
    parameter int PIXEL_SIZE    = 16,
    parameter int PRECISION     = 11,
    parameter int FG_WIDTH      = 800,
    parameter int FG_HEIGHT     = 600,
    parameter int ADDR_WIDTH    = 19,
    parameter int FETCH_DELAY   = 3,
    parameter int SRAM_RD_LAT   = 1,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [PRECISION:0]   req_x,
    input  logic signed [PRECISION:0]   req_y,
    input  logic                        req_active,
    output logic [PIXEL_SIZE-1:0]       fg_pixel_out,
    output logic                        fg_pixel_skip,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [PIXEL_SIZE-1:0]       wr_data,
    output logic                        wr_overflow,
    output logic [ADDR_WIDTH-1:0]       sram_addr,
    output logic                        sram_re,
    output logic                        sram_we,
    output logic [PIXEL_SIZE-1:0]       sram_wdata,
    input  logic [PIXEL_SIZE-1:0]       sram_rdata
);

    // Hit flags ride alongside the read until the output register; with
    // SRAM_RD_LAT == FETCH_DELAY-2 both terms agree.
    localparam int PIPE_W = (FETCH_DELAY - 1 > SRAM_RD_LAT + 1) ? FETCH_DELAY - 1 : SRAM_RD_LAT + 1;
    localparam int IDX_W  = $clog2(WR_FIFO_DEPTH);
    localparam int PTR_W  = IDX_W + 1;

    localparam logic signed [PRECISION:0] FG_W_S = (PRECISION+1)'(FG_WIDTH);
    localparam logic signed [PRECISION:0] FG_H_S = (PRECISION+1)'(FG_HEIGHT);
    localparam logic [ADDR_WIDTH-1:0]     FG_W_A = ADDR_WIDTH'(FG_WIDTH);

    logic                   hit;
    logic [ADDR_WIDTH-1:0]  rd_addr;
    logic [ADDR_WIDTH-1:0]  x_ext;
    logic [ADDR_WIDTH-1:0]  y_ext;
    logic [PIPE_W-1:0]      hit_pipe;

    logic [ADDR_WIDTH-1:0]  fifo_addr [WR_FIFO_DEPTH];
    logic [PIXEL_SIZE-1:0]  fifo_data [WR_FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic                   fifo_empty;
    logic                   fifo_full;
    logic                   push;
    logic                   pop;

    always_comb begin
        hit   = req_active
              && !req_x[PRECISION] && (req_x < FG_W_S)
              && !req_y[PRECISION] && (req_y < FG_H_S);
        x_ext   = ADDR_WIDTH'($unsigned(req_x));
        y_ext   = ADDR_WIDTH'($unsigned(req_y));
        rd_addr = y_ext * FG_W_A + x_ext;
    end

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1])
                  && (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        wr_ready   = ~fifo_full & ~rst;
        push       = wr_valid & wr_ready;
        pop        = ~hit & ~fifo_empty;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr[IDX_W-1:0]] <= wr_addr;
            fifo_data[wr_ptr[IDX_W-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            hit_pipe      <= '0;
            sram_re       <= 1'b0;
            sram_we       <= 1'b0;
            sram_addr     <= '0;
            sram_wdata    <= '0;
            fg_pixel_out  <= '0;
            fg_pixel_skip <= 1'b1;
            wr_overflow   <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;

            // A read always wins the port; a queued write only takes a read-free slot.
            sram_re <= hit;
            sram_we <= pop;
            if (hit) begin
                sram_addr <= rd_addr;
            end else if (pop) begin
                sram_addr  <= fifo_addr[rd_ptr[IDX_W-1:0]];
                sram_wdata <= fifo_data[rd_ptr[IDX_W-1:0]];
                rd_ptr     <= rd_ptr + 1'b1;
            end

            hit_pipe      <= {hit_pipe[PIPE_W-2:0], hit};
            fg_pixel_skip <= ~hit_pipe[PIPE_W-1];
            if (hit_pipe[PIPE_W-1])
                fg_pixel_out <= sram_rdata;

            if (wr_valid & ~wr_ready)
                wr_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fg_fetch_sram_port.sv
// Scoreboard bench for fg_fetch_sram_port: stimulus pushes per-slot expectations,
// a negedge monitor pops them when they fall due and compares against the DUT.
module tb_fg_fetch_sram_port;

    localparam int W   = 800;
    localparam int H   = 600;
    localparam int AW  = 19;
    localparam int PS  = 16;
    localparam int PRC = 11;

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [PRC:0]  req_x;
    logic signed [PRC:0]  req_y;
    logic                 req_active;
    logic [PS-1:0]        fg_pixel_out;
    logic                 fg_pixel_skip;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [AW-1:0]        wr_addr;
    logic [PS-1:0]        wr_data;
    logic                 wr_overflow;
    logic [AW-1:0]        sram_addr;
    logic                 sram_re;
    logic                 sram_we;
    logic [PS-1:0]        sram_wdata;
    logic [PS-1:0]        sram_rdata;

    always #5 clk = ~clk;

    fg_fetch_sram_port #(
        .PIXEL_SIZE(PS), .PRECISION(PRC), .FG_WIDTH(W), .FG_HEIGHT(H),
        .ADDR_WIDTH(AW), .FETCH_DELAY(3), .SRAM_RD_LAT(1), .WR_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .req_x(req_x), .req_y(req_y), .req_active(req_active),
        .fg_pixel_out(fg_pixel_out), .fg_pixel_skip(fg_pixel_skip),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_overflow(wr_overflow), .sram_addr(sram_addr), .sram_re(sram_re),
        .sram_we(sram_we), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // SRAM content is a fixed function of the address; reads of 1610 return 1610.
    function automatic logic [PS-1:0] rd_pat(input logic [AW-1:0] a);
        return a[15:0] ^ {a[18:16], 13'd0};
    endfunction

    always @(posedge clk)
        sram_rdata <= sram_re ? rd_pat(sram_addr) : 16'hDEAD;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int due; bit hit; bit rst; logic [AW-1:0] addr; } resp_t;
    typedef struct { int due; bit rst; bit re; bit we; logic [AW-1:0] addr;
                     logic [PS-1:0] data; bit ov; } port_t;
    typedef struct { logic [AW-1:0] a; logic [PS-1:0] d; } wr_t;

    resp_t rq[$];
    port_t pq[$];
    wr_t   fifo_m[$];
    bit    ov_m;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // One request slot: drive inputs, then advance the reference model.
    task automatic step(input bit r, input bit act, input int x, input int y,
                        input bit wv, input logic [AW-1:0] wa, input logic [PS-1:0] wd);
        int    c;
        bit    hit, exp_ready, pop;
        port_t pe;
        resp_t re;
        @(posedge clk);
        #1;
        rst = r; req_active = act; req_x = 12'(x); req_y = 12'(y);
        wr_valid = wv; wr_addr = wa; wr_data = wd;
        c = cyc;
        hit = !r && act && x >= 0 && x < W && y >= 0 && y < H;
        exp_ready = !r && fifo_m.size() < 4;
        #1;
        chk("wr_ready", 32'(wr_ready), 32'(exp_ready));
        if (r) begin
            foreach (rq[i])
                if (rq[i].due >= c + 1) begin rq[i].hit = 0; rq[i].rst = 1; end
            fifo_m.delete();
            ov_m = 0;
            re = '{due: c + 3, hit: 0, rst: 1, addr: '0};
            pe = '{due: c + 1, rst: 1, re: 0, we: 0, addr: '0, data: '0, ov: 0};
        end else begin
            pop = !hit && fifo_m.size() > 0;
            pe = '{due: c + 1, rst: 0, re: hit, we: pop, addr: '0, data: '0, ov: 0};
            if (hit) pe.addr = 19'(y * W + x);
            else if (pop) begin pe.addr = fifo_m[0].a; pe.data = fifo_m[0].d; end
            if (pop) void'(fifo_m.pop_front());
            if (wv && exp_ready) fifo_m.push_back('{a: wa, d: wd});
            if (wv && !exp_ready) ov_m = 1;
            pe.ov = ov_m;
            re = '{due: c + 3, hit: hit, rst: 0, addr: 19'(y * W + x)};
        end
        rq.push_back(re);
        pq.push_back(pe);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, '0, '0);
    endtask

    // Monitor: every slot is a response; compare whatever falls due this cycle.
    logic [PS-1:0] last_pix = '0;
    always @(negedge clk) begin
        resp_t e;
        port_t p;
        logic [PS-1:0] exp_pix;
        if (cyc > 1) begin
            checks++;
            if (sram_re === 1'b1 && sram_we === 1'b1) begin
                errors++;
                $display("FAIL re_we_exclusive @cyc %0d: got re=1 we=1 expected not both", cyc);
            end
        end
        while (rq.size() > 0 && rq[0].due <= cyc) begin
            e = rq.pop_front();
            if (e.due < cyc) chk("resp_order", 32'(e.due), 32'(cyc));
            if (e.rst) last_pix = '0;
            exp_pix = e.hit ? rd_pat(e.addr) : last_pix;
            if (e.hit) last_pix = exp_pix;
            chk("fg_pixel_skip", 32'(fg_pixel_skip), 32'(!e.hit));
            chk("fg_pixel_out", 32'(fg_pixel_out), 32'(exp_pix));
        end
        while (pq.size() > 0 && pq[0].due <= cyc) begin
            p = pq.pop_front();
            chk("sram_re", 32'(sram_re), 32'(p.re));
            chk("sram_we", 32'(sram_we), 32'(p.we));
            chk("wr_overflow", 32'(wr_overflow), 32'(p.ov));
            if (p.re || p.we || p.rst) chk("sram_addr", 32'(sram_addr), 32'(p.addr));
            if (p.we || p.rst) chk("sram_wdata", 32'(sram_wdata), 32'(p.data));
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; req_active = 0; req_x = '0; req_y = '0;
        wr_valid = 0; wr_addr = '0; wr_data = '0;

        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, '0, '0);
        idle(4);

        // single hit at (10,2) -> address and pixel 1610
        step(0, 1, 10, 2, 0, '0, '0);
        idle(4);

        // out-of-range and inactive requests
        step(0, 1, -1, 0, 0, '0, '0);
        step(0, 1, 800, 5, 0, '0, '0);
        step(0, 1, 0, 600, 0, '0, '0);
        step(0, 0, 5, 5, 0, '0, '0);
        idle(4);

        // 600 back-to-back hits on one line
        for (int i = 0; i < 600; i++) step(0, 1, 100 + i, 7, 0, '0, '0);
        idle(2);

        // 6 writes against continuous reads, then wr_valid held, then drain
        for (int i = 0; i < 6; i++)
            step(0, 1, i, 3, 1, 19'(1000 + i), 16'(16'hA000 + i));
        for (int i = 0; i < 3; i++) step(0, 1, 50 + i, 4, 1, 19'h7FFFF, 16'hBEEF);
        idle(8);

        // reset one cycle after a hit request
        step(0, 1, 20, 20, 1, 19'd77, 16'h1234);
        step(1, 1, 21, 20, 0, '0, '0);
        idle(6);

        // randomized mixed traffic
        for (int i = 0; i < 10000; i++) begin
            bit r, act, wv;
            r   = ($urandom_range(0, 999) < 2);
            act = ($urandom_range(0, 99) < 70);
            wv  = ($urandom_range(0, 99) < 30);
            step(r, act, int'($urandom_range(0, 840)) - 20, int'($urandom_range(0, 640)) - 20,
                 wv, 19'($urandom), 16'($urandom));
        end

        idle(12);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        chk("fifo_drained", 32'(fifo_m.size()), 32'd0);
        chk("resp_queue_empty", 32'(rq.size()), 32'd0);
        chk("port_queue_empty", 32'(pq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
